// File: rtl/mmio_bus_pkg.sv
// Shared types and constants for the MMIO bus bridge and its address decoder.
package mmio_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Fill bit for the read data returned on a bus error; replicated to DATA_WIDTH.
    localparam logic ERROR_RDATA = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational MMIO window decode: processor address -> {hit, one-hot slot}.
module mmio_addr_decode
    import mmio_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SLOT_SHIFT = 12,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = 64'hFFFF_FFFF_FFFF_0000
) (
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] slot_onehot
);

    localparam int unsigned SLOT_BITS = width_of(NUM_SLAVES);
    localparam logic [ADDR_WIDTH-1:0] WINDOW_MASK =
        ~((ADDR_WIDTH'(NUM_SLAVES) << SLOT_SHIFT) - ADDR_WIDTH'(1));

    logic                 in_window;
    logic [SLOT_BITS-1:0] slot_idx;

    assign in_window = ((address & WINDOW_MASK) == MMIO_BASE);
    assign slot_idx  = address[SLOT_SHIFT +: SLOT_BITS];

    // A slot index beyond NUM_SLAVES (non power-of-two counts) is treated as unmapped.
    always_comb begin
        hit         = 1'b0;
        slot_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (in_window && (slot_idx == SLOT_BITS'(i))) begin
                slot_onehot[i] = 1'b1;
                hit            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Processor-to-peripheral MMIO bridge with registered outputs and bus-error responses.
// Define MMIO_TIMEOUT_EN to bound slave wait time by TIMEOUT_CYCLES.
module mmio_bus_bridge
    import mmio_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SLOT_SHIFT     = 12,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = 64'hFFFF_FFFF_FFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDR_WIDTH-1:0]            m_address,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic                             m_read,
    input  logic                             m_write,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_ready,
    output logic                             m_error,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic                             s_read,
    output logic                             s_write,
    output logic [SLOT_SHIFT-1:0]            s_offset,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ack
);

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    rd_q, rd_d, wr_q, wr_d;
    logic [SLOT_SHIFT-1:0]   off_q, off_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    error_q, error_d;

    logic                    hit;
    logic [NUM_SLAVES-1:0]   slot_onehot;
    logic                    ack_hit;
    logic                    timeout_hit;
    logic [DATA_WIDTH-1:0]   slave_rdata;

    mmio_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLOT_SHIFT (SLOT_SHIFT),
        .MMIO_BASE  (MMIO_BASE)
    ) u_decode (
        .address     (m_address),
        .hit         (hit),
        .slot_onehot (slot_onehot)
    );

    // Acks from slaves other than the selected one never complete an access.
    assign ack_hit = |(s_ack & sel_q);

    always_comb begin
        slave_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) slave_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CNT_W = width_of(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Counter holds the number of completed ACCESS cycles; cleared outside ACCESS.
    always_comb begin
        count_d = '0;
        if (state_q == ACCESS) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign timeout_hit = (count_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (m_read || m_write) begin
                    if ((m_read && m_write) || !hit) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                        rdata_d = {DATA_WIDTH{ERROR_RDATA}};
                    end else begin
                        state_d = ACCESS;
                        sel_d   = slot_onehot;
                        rd_d    = m_read;
                        wr_d    = m_write;
                        off_d   = m_address[SLOT_SHIFT-1:0];
                        wdata_d = m_wdata;
                    end
                end
            end
            ACCESS: begin
                // Ack on the timeout edge still counts as success.
                if (ack_hit) begin
                    state_d = RESP;
                    sel_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b0;
                    if (rd_q) rdata_d = slave_rdata;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    sel_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    rdata_d = {DATA_WIDTH{ERROR_RDATA}};
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign s_sel    = sel_q;
    assign s_read   = rd_q;
    assign s_write  = wr_q;
    assign s_offset = off_q;
    assign s_wdata  = wdata_q;
    assign m_rdata  = rdata_q;
    assign m_ready  = ready_q;
    assign m_error  = error_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed self-checking bench for mmio_bus_bridge with a delayed-ack slave model.
module tb_mmio_bus_bridge;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int NS = 4;
    localparam int SS = 12;
    localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   m_address = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic            m_read = 1'b0;
    logic            m_write = 1'b0;
    logic [DW-1:0]   m_rdata;
    logic            m_ready;
    logic            m_error;
    logic [NS-1:0]   s_sel;
    logic            s_read;
    logic            s_write;
    logic [SS-1:0]   s_offset;
    logic [DW-1:0]   s_wdata;
    logic [NS*DW-1:0] s_rdata = '0;
    logic [NS-1:0]   s_ack;

    int              n_checks = 0;
    int              n_fail = 0;
    int              wait_cnt = 0;
    int              ack_delay = 0;
    logic [NS-1:0]   extra_ack = '0;

    int              lat, rd_cyc, wr_cyc;
    logic [NS-1:0]   sel_seen;
    logic [SS-1:0]   off_seen;
    logic [DW-1:0]   wd_seen;
    logic            got;

    mmio_bus_bridge dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .m_error   (m_error),
        .s_sel     (s_sel),
        .s_read    (s_read),
        .s_write   (s_write),
        .s_offset  (s_offset),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ack     (s_ack)
    );

    always #5 clock = ~clock;

    // Slave model: acks combinationally once the strobe has been high for ack_delay cycles.
    always @(posedge clock) wait_cnt <= (s_read || s_write) ? wait_cnt + 1 : 0;
    always_comb s_ack = ((wait_cnt >= ack_delay) ? s_sel : '0) | extra_ack;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called with the request already driven; the first edge in the loop samples it.
    task automatic run_to_ready(input int budget);
        lat = 0; rd_cyc = 0; wr_cyc = 0; got = 1'b0;
        sel_seen = '0; off_seen = '0; wd_seen = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            lat = i + 1;
            if (s_read)  rd_cyc++;
            if (s_write) wr_cyc++;
            if (s_read || s_write) begin
                off_seen = s_offset;
                wd_seen  = s_wdata;
            end
            sel_seen |= s_sel;
            if (m_ready) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #12;
        check("rst_ready", {63'd0, m_ready}, 64'd0);
        check("rst_error", {63'd0, m_error}, 64'd0);
        check("rst_rdata", m_rdata, 64'd0);
        check("rst_sel",   {60'd0, s_sel}, 64'd0);
        check("rst_strobe", {62'd0, s_read, s_write}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Read slot 1, combinational ack
        m_address = BASE + 64'h1008;
        m_read = 1'b1;
        s_rdata[1*DW +: DW] = 64'h1234;
        ack_delay = 0;
        run_to_ready(20);
        check("rd1_got",   {63'd0, got}, 64'd1);
        check("rd1_lat",   64'(lat), 64'd2);
        check("rd1_rdcyc", 64'(rd_cyc), 64'd1);
        check("rd1_wrcyc", 64'(wr_cyc), 64'd0);
        check("rd1_sel",   {60'd0, sel_seen}, 64'b0010);
        check("rd1_off",   {52'd0, off_seen}, 64'h008);
        check("rd1_rdata", m_rdata, 64'h1234);
        check("rd1_error", {63'd0, m_error}, 64'd0);
        m_read = 1'b0;
        tick();
        check("rd1_pulse", {63'd0, m_ready}, 64'd0);

        // Write slot 3 after 4 wait cycles; a stray ack from slot 0 must be ignored
        m_address = BASE + 64'h3010;
        m_wdata = 64'hA5;
        m_write = 1'b1;
        ack_delay = 4;
        extra_ack = 4'b0001;
        run_to_ready(20);
        check("wr3_got",   {63'd0, got}, 64'd1);
        check("wr3_lat",   64'(lat), 64'd6);
        check("wr3_wrcyc", 64'(wr_cyc), 64'd5);
        check("wr3_rdcyc", 64'(rd_cyc), 64'd0);
        check("wr3_sel",   {60'd0, sel_seen}, 64'b1000);
        check("wr3_off",   {52'd0, off_seen}, 64'h010);
        check("wr3_wdata", wd_seen, 64'hA5);
        check("wr3_error", {63'd0, m_error}, 64'd0);
        m_write = 1'b0;
        extra_ack = '0;
        tick();

        // Unmapped read
        m_address = 64'h0000_1000;
        m_read = 1'b1;
        ack_delay = 0;
        run_to_ready(20);
        check("unm_lat",   64'(lat), 64'd1);
        check("unm_sel",   {60'd0, sel_seen}, 64'd0);
        check("unm_rdcyc", 64'(rd_cyc), 64'd0);
        check("unm_error", {63'd0, m_error}, 64'd1);
        check("unm_rdata", m_rdata, ONES);
        m_read = 1'b0;
        tick();

        // Read and write together on a mapped address
        m_address = BASE + 64'h2000;
        m_read = 1'b1;
        m_write = 1'b1;
        run_to_ready(20);
        check("both_lat",   64'(lat), 64'd1);
        check("both_strb",  64'(rd_cyc + wr_cyc), 64'd0);
        check("both_sel",   {60'd0, sel_seen}, 64'd0);
        check("both_error", {63'd0, m_error}, 64'd1);
        m_read = 1'b0;
        m_write = 1'b0;
        tick();

        // Read slot 0 after errors: error clears, data replaces all-ones
        m_address = BASE + 64'h0FF0;
        m_read = 1'b1;
        s_rdata[0 +: DW] = 64'h55;
        ack_delay = 2;
        run_to_ready(20);
        check("rd0_lat",   64'(lat), 64'd4);
        check("rd0_off",   {52'd0, off_seen}, 64'hFF0);
        check("rd0_rdata", m_rdata, 64'h55);
        check("rd0_error", {63'd0, m_error}, 64'd0);
        m_read = 1'b0;
        tick();

        // Slave slot 2 never acks
        m_address = BASE + 64'h2020;
        m_read = 1'b1;
        ack_delay = 1000000;
`ifdef MMIO_TIMEOUT_EN
        run_to_ready(300);
        check("to_got",   {63'd0, got}, 64'd1);
        check("to_lat",   64'(lat), 64'd257);
        check("to_error", {63'd0, m_error}, 64'd1);
        check("to_rdata", m_rdata, ONES);
        m_read = 1'b0;
        tick();
        m_read = 1'b1;
        run_to_ready(10);
        check("hang_got", {63'd0, got}, 64'd0);
`else
        run_to_ready(300);
        check("hang_got", {63'd0, got}, 64'd0);
        check("hang_lat", 64'(lat), 64'd300);
`endif
        check("hang_sel",  {60'd0, s_sel}, 64'b0100);
        check("hang_read", {63'd0, s_read}, 64'd1);

        // Asynchronous reset in the middle of the hung access
        #2;
        reset_n = 1'b0;
        m_read = 1'b0;
        #1;
        check("ar_sel",   {60'd0, s_sel}, 64'd0);
        check("ar_strb",  {62'd0, s_read, s_write}, 64'd0);
        check("ar_ready", {63'd0, m_ready}, 64'd0);
        check("ar_rdata", m_rdata, 64'd0);
        tick();
        tick();
        check("ar_hold_ready", {63'd0, m_ready}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Fresh read of slot 2 after reset
        m_address = BASE + 64'h2FF8;
        m_read = 1'b1;
        s_rdata[2*DW +: DW] = 64'hDEAD_BEEF_CAFE_0123;
        ack_delay = 1;
        run_to_ready(20);
        check("rd2_got",   {63'd0, got}, 64'd1);
        check("rd2_lat",   64'(lat), 64'd3);
        check("rd2_rdcyc", 64'(rd_cyc), 64'd2);
        check("rd2_sel",   {60'd0, sel_seen}, 64'b0100);
        check("rd2_off",   {52'd0, off_seen}, 64'hFF8);
        check("rd2_rdata", m_rdata, 64'hDEAD_BEEF_CAFE_0123);
        check("rd2_error", {63'd0, m_error}, 64'd0);
        m_read = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
